cfg_bitstream_loader: RTL

//  Transmit end of the fabric configuration path. Reads configuration words
//  (LUT contents, switch/connection-box configure fields) from a synchronous

---
 rtl/cfg_bitstream_loader_if.sv | 47 ++++
 rtl/cfg_bitstream_loader.sv | 137 +++++++++++++
 2 files changed

// File: rtl/cfg_bitstream_loader_if.sv
`default_nettype none
// ============================================================================
// Module  : cfg_bitstream_loader_if
// Brief   : Config-RAM read port plus serial scan-chain output bundle for
//           the bitstream loader.
// Revision: 1.0 - initial release
// ============================================================================
interface cfg_bitstream_loader_if #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 4
);
    logic              start;
    logic              hold;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic              sout;
    logic              sen;
    logic              busy;
    logic              done;

    // The loader drives the RAM read port and the scan chain.
    modport master (
        input  start,
        input  hold,
        input  rd_data,
        output rd_en,
        output rd_addr,
        output sout,
        output sen,
        output busy,
        output done
    );

    modport slave (
        output start,
        output hold,
        output rd_data,
        input  rd_en,
        input  rd_addr,
        input  sout,
        input  sen,
        input  busy,
        input  done
    );
endinterface
`default_nettype wire

// File: rtl/cfg_bitstream_loader.sv
`default_nettype none
// ============================================================================
// Module  : cfg_bitstream_loader
// Brief   : Reads configuration words from a synchronous RAM and shifts them
//           MSB-first onto the fabric scan chain with a shift-enable.
// Revision: 1.0 - initial release
// ============================================================================
module cfg_bitstream_loader #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 15,
    parameter int ADDR_W    = 4
) (
    input wire                     clk,
    input wire                     rst_n,
    cfg_bitstream_loader_if.master bus
);

    localparam int                BIT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t              state_q,    state_d;
    logic [WORD_W-1:0]   shreg_q,    shreg_d;
    logic [BIT_W-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
    logic                rd_en_q,    rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q,  rd_addr_d;
    logic                sout_q,     sout_d;
    logic                sen_q,      sen_d;
    logic                busy_q,     busy_d;
    logic                done_q,     done_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            word_idx_q <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            sout_q     <= 1'b0;
            sen_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            word_idx_q <= word_idx_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            sout_q     <= sout_d;
            sen_q      <= sen_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        word_idx_d = word_idx_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        sout_d     = sout_q;
        sen_d      = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A start coinciding with the done pulse must not relaunch.
                if (bus.start && !done_q) begin
                    state_d    = S_READ;
                    busy_d     = 1'b1;
                    rd_en_d    = 1'b1;
                    rd_addr_d  = '0;
                    word_idx_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            S_READ: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                shreg_d   = bus.rd_data;
                bit_cnt_d = '0;
                state_d   = S_SHIFT;
            end
            S_SHIFT: begin
                if (!bus.hold) begin
                    sout_d    = shreg_q[WORD_W-1];
                    sen_d     = 1'b1;
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        if (word_idx_q == LAST_IDX) begin
                            state_d = S_FIN;
                        end else begin
                            word_idx_d = word_idx_q + ADDR_W'(1);
                            rd_addr_d  = word_idx_q + ADDR_W'(1);
                            rd_en_d    = 1'b1;
                            state_d    = S_READ;
                        end
                    end
                end
            end
            S_FIN: begin
                sout_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.sout    = sout_q;
    assign bus.sen     = sen_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule
`default_nettype wire
